// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and line/beat geometry for the line responder
package pmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_RESP
  } pmem_state_t;

  localparam int PMEM_LINE_W      = 256;
  localparam int PMEM_BEAT_W      = 64;
  localparam int PMEM_BEATS       = 4;
  localparam int PMEM_OFFSET_BITS = 5;

endpackage

// File: rtl/pmem_beat_array.sv
// rtl/pmem_beat_array.sv - single-port beat-wide storage, synchronous write, combinational read
module pmem_beat_array
  import pmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [PMEM_BEAT_W-1:0] wdata,
  output logic [PMEM_BEAT_W-1:0] rdata
);

  logic [PMEM_BEAT_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - fixed-latency cache-line memory responder; PMEM_LINE_RESPONDER_STATS_EN adds op counters
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int LINE_IDX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            mem_address,
  input  logic [PMEM_LINE_W-1:0] mem_wdata,
  output logic [PMEM_LINE_W-1:0] mem_rdata,
  output logic                   mem_resp,
  output logic                   proto_err
`ifdef PMEM_LINE_RESPONDER_STATS_EN
  ,
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writes
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  pmem_state_t            state;
  logic [CNT_W-1:0]       wait_cnt;
  logic [1:0]             beat;
  logic [LINE_IDX_W-1:0]  line_idx;
  logic [PMEM_LINE_W-1:0] wdata_q;
  logic                   op_write;

  logic                   arr_we;
  logic [PMEM_BEAT_W-1:0] arr_rdata;

  // Gating with rst_n keeps a beat from committing on the edge that resets the FSM.
  assign arr_we = (state == ST_XFER) && op_write && rst_n;

  pmem_beat_array #(
    .ADDR_W(LINE_IDX_W + 2)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr ({line_idx, beat}),
    .wdata(wdata_q[{beat, 6'b0} +: PMEM_BEAT_W]),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      beat      <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
`ifdef PMEM_LINE_RESPONDER_STATS_EN
      stat_reads  <= '0;
      stat_writes <= '0;
`endif
    end else begin
      mem_resp <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            line_idx <= mem_address[PMEM_OFFSET_BITS +: LINE_IDX_W];
            wdata_q  <= mem_wdata;
            op_write <= mem_write;
            if (mem_read && mem_write) proto_err <= 1'b1;
            wait_cnt <= CNT_LOAD;
            beat     <= '0;
            state    <= (LATENCY == 0) ? ST_XFER : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_XFER;
          else wait_cnt <= wait_cnt - 1'b1;
        end
        ST_XFER: begin
          if (!op_write) mem_rdata[{beat, 6'b0} +: PMEM_BEAT_W] <= arr_rdata;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state    <= ST_RESP;
            mem_resp <= 1'b1;
`ifdef PMEM_LINE_RESPONDER_STATS_EN
            // Counters become visible in the same cycle mem_resp is high.
            if (op_write) begin
              if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
            end else begin
              if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
            end
`endif
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
